priority_encode_scan: RTL and testbench



---
 rtl/encode_display_pkg.sv | 30 +++
 rtl/seg7_decode.sv | 36 +++
 rtl/priority_encode_scan.sv | 162 ++++++++++++++++
 tb/tb_priority_encode_scan.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/encode_display_pkg.sv
// Shared seven-segment glyphs and digit-bank constants for the priority encoder display.
package encode_display_pkg;

  localparam int unsigned DIGITS = 4;

  // bit0..6 = a..g, bit7 = dp (always off)
  localparam logic [7:0] GLYPH_0     = 8'h3F;
  localparam logic [7:0] GLYPH_1     = 8'h06;
  localparam logic [7:0] GLYPH_2     = 8'h5B;
  localparam logic [7:0] GLYPH_3     = 8'h4F;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'h6D;
  localparam logic [7:0] GLYPH_6     = 8'h7D;
  localparam logic [7:0] GLYPH_7     = 8'h07;
  localparam logic [7:0] GLYPH_8     = 8'h7F;
  localparam logic [7:0] GLYPH_9     = 8'h6F;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;
  localparam logic [7:0] GLYPH_E     = 8'h79;
  localparam logic [7:0] GLYPH_H     = 8'h76;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  typedef enum logic [2:0] {
    GlyphDigit,
    GlyphDash,
    GlyphE,
    GlyphH,
    GlyphBlank
  } glyph_sel_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph lookup: a decimal digit or a fixed status glyph to segment pattern.
module seg7_decode
  import encode_display_pkg::*;
(
  input  logic [3:0]  digit,
  input  glyph_sel_e  sel,
  output logic [7:0]  seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    unique case (sel)
      GlyphDigit: begin
        case (digit)
          4'd0:    seg = GLYPH_0;
          4'd1:    seg = GLYPH_1;
          4'd2:    seg = GLYPH_2;
          4'd3:    seg = GLYPH_3;
          4'd4:    seg = GLYPH_4;
          4'd5:    seg = GLYPH_5;
          4'd6:    seg = GLYPH_6;
          4'd7:    seg = GLYPH_7;
          4'd8:    seg = GLYPH_8;
          4'd9:    seg = GLYPH_9;
          default: seg = GLYPH_BLANK;
        endcase
      end
      GlyphDash:  seg = GLYPH_DASH;
      GlyphE:     seg = GLYPH_E;
      GlyphH:     seg = GLYPH_H;
      GlyphBlank: seg = GLYPH_BLANK;
      default:    seg = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/priority_encode_scan.sv
// Synchronised priority encoder (highest index wins) with optional hold, driving two
// scanned 4-digit seven-segment banks: decimal code on the left, status glyphs on the right.
module priority_encode_scan
  import encode_display_pkg::*;
#(
  parameter int unsigned N_IN     = 16,
  parameter int unsigned SCAN_DIV = 50000,
  localparam int unsigned IW      = $clog2(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            n_EN,
  input  logic            hold,
  input  logic [N_IN-1:0] Datain,
  output logic [N_IN-1:0] switch_led,
  output logic [IW-1:0]   code,
  output logic            valid,
  output logic            ET,
  output logic [7:0]      a_to_g_left,
  output logic [7:0]      a_to_g_right,
  output logic [3:0]      leftseg,
  output logic [3:0]      rightseg
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam int unsigned XW = $clog2(DIGITS);

  logic [N_IN-1:0] data_s1_q, data_s2_q;
  logic            nen_s1_q, nen_s2_q;
  logic [IW-1:0]   code_q, code_d, held_q, held_d, live_idx;
  logic            valid_q, valid_d, et_q, et_d, held_vld_q, held_vld_d, live_any;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XW-1:0]   idx_q, idx_d;
  logic [7:0]      seg_left_q, seg_right_q, seg_left_c, seg_right_c;
  logic [6:0]      code_ext;
  logic [3:0]      units, tens, left_digit;
  glyph_sel_e      left_sel, right_sel;

  // Ascending scan so the last (highest) set bit overrides lower ones.
  always_comb begin
    live_idx = '0;
    live_any = 1'b0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (data_s2_q[i]) begin
        live_idx = IW'(i);
        live_any = 1'b1;
      end
    end
  end

  always_comb begin
    code_d     = '0;
    valid_d    = 1'b0;
    et_d       = 1'b0;
    held_d     = held_q;
    held_vld_d = held_vld_q;
    if (nen_s2_q) begin
      held_d     = '0;
      held_vld_d = 1'b0;
    end else if (live_any) begin
      code_d     = live_idx;
      valid_d    = 1'b1;
      held_d     = live_idx;
      held_vld_d = 1'b1;
    end else begin
      et_d = 1'b1;
      if (hold && held_vld_q) begin
        code_d  = held_q;
        valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 1'b1;
    end
  end

  // Code is below 64, so a 7-bit divide/modulo by 10 covers every legal width.
  assign code_ext = 7'(code_q);
  assign units    = 4'(code_ext % 7'd10);
  assign tens     = 4'(code_ext / 7'd10);

  // Glyphs are chosen for the upcoming digit index so segments and select change together.
  always_comb begin
    left_sel   = GlyphBlank;
    left_digit = units;
    right_sel  = GlyphBlank;
    unique case (idx_d)
      XW'(0): begin
        if (valid_q) left_sel = GlyphDigit;
        else         left_sel = GlyphDash;
        if (hold)    right_sel = GlyphH;
      end
      XW'(1): begin
        left_digit = tens;
        if (!valid_q)          left_sel = GlyphDash;
        else if (tens != 4'd0) left_sel = GlyphDigit;
        if (nen_s2_q)          right_sel = GlyphE;
      end
      default: ;
    endcase
  end

  seg7_decode u_left_decode (
    .digit (left_digit),
    .sel   (left_sel),
    .seg   (seg_left_c)
  );

  seg7_decode u_right_decode (
    .digit (4'd0),
    .sel   (right_sel),
    .seg   (seg_right_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_s1_q   <= '0;
      data_s2_q   <= '0;
      nen_s1_q    <= 1'b0;
      nen_s2_q    <= 1'b0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      et_q        <= 1'b0;
      held_q      <= '0;
      held_vld_q  <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      seg_left_q  <= GLYPH_BLANK;
      seg_right_q <= GLYPH_BLANK;
    end else begin
      data_s1_q   <= Datain;
      data_s2_q   <= data_s1_q;
      nen_s1_q    <= n_EN;
      nen_s2_q    <= nen_s1_q;
      code_q      <= code_d;
      valid_q     <= valid_d;
      et_q        <= et_d;
      held_q      <= held_d;
      held_vld_q  <= held_vld_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      seg_left_q  <= seg_left_c;
      seg_right_q <= seg_right_c;
    end
  end

  assign switch_led   = data_s2_q;
  assign code         = code_q;
  assign valid        = valid_q;
  assign ET           = et_q;
  assign a_to_g_left  = seg_left_q;
  assign a_to_g_right = seg_right_q;
  assign leftseg      = 4'b0001 << idx_q;
  assign rightseg     = 4'b0001 << idx_q;

endmodule

// File: tb/tb_priority_encode_scan.sv
// Directed self-checking bench for priority_encode_scan with N_IN=16, SCAN_DIV=4.
module tb_priority_encode_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        n_EN = 1'b1;
  logic        hold = 1'b0;
  logic [15:0] Datain = '0;
  logic [15:0] switch_led;
  logic [3:0]  code;
  logic        valid, ET;
  logic [7:0]  a_to_g_left, a_to_g_right;
  logic [3:0]  leftseg, rightseg;

  int checks = 0;
  int failures = 0;

  priority_encode_scan #(
    .N_IN     (16),
    .SCAN_DIV (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .n_EN         (n_EN),
    .hold         (hold),
    .Datain       (Datain),
    .switch_led   (switch_led),
    .code         (code),
    .valid        (valid),
    .ET           (ET),
    .a_to_g_left  (a_to_g_left),
    .a_to_g_right (a_to_g_right),
    .leftseg      (leftseg),
    .rightseg     (rightseg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a digit select; callers compare leftseg afterwards, so expiry fails.
  task automatic wait_sel(input logic [3:0] sel);
    int n = 0;
    while (leftseg !== sel && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (code !== 4'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", code); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (ET !== 1'b0) begin failures++; $display("FAIL reset_et got=%b exp=0", ET); end
    checks++; if (leftseg !== 4'b0001 || rightseg !== 4'b0001) begin
      failures++; $display("FAIL reset_sel got=%b/%b exp=0001/0001", leftseg, rightseg);
    end
    checks++; if (a_to_g_left !== 8'h00 || a_to_g_right !== 8'h00) begin
      failures++; $display("FAIL reset_seg got=%h/%h exp=00/00", a_to_g_left, a_to_g_right);
    end
    checks++; if (switch_led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=0", switch_led); end
  endtask

  task automatic test_priority();
    @(posedge clk);
    #1;
    rst = 1'b0; n_EN = 1'b0; Datain = 16'h0090;
    tick(); tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL prio_early_valid got=%b exp=0", valid); end
    checks++; if (switch_led !== 16'h0090) begin failures++; $display("FAIL prio_led got=%h exp=0090", switch_led); end
    tick();
    checks++; if (code !== 4'd7) begin failures++; $display("FAIL prio_code got=%0d exp=7", code); end
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL prio_valid got=%b exp=1", valid); end
    checks++; if (ET !== 1'b0) begin failures++; $display("FAIL prio_et got=%b exp=0", ET); end
    tick();
    wait_sel(4'b0001);
    checks++; if (leftseg !== 4'b0001 || a_to_g_left !== 8'h07) begin
      failures++; $display("FAIL prio_dig0 got=%b/%h exp=0001/07", leftseg, a_to_g_left);
    end
    wait_sel(4'b0010);
    checks++; if (leftseg !== 4'b0010 || a_to_g_left !== 8'h00) begin
      failures++; $display("FAIL prio_dig1 got=%b/%h exp=0010/00", leftseg, a_to_g_left);
    end
  endtask

  task automatic test_two_digits();
    logic [3:0] exp_sel;
    Datain = 16'h8001;
    repeat (4) tick();
    checks++; if (code !== 4'd15) begin failures++; $display("FAIL two_code got=%0d exp=15", code); end
    wait_sel(4'b0001);
    checks++; if (leftseg !== 4'b0001 || a_to_g_left !== 8'h6D) begin
      failures++; $display("FAIL two_dig0 got=%b/%h exp=0001/6d", leftseg, a_to_g_left);
    end
    wait_sel(4'b0010);
    checks++; if (leftseg !== 4'b0010 || a_to_g_left !== 8'h06) begin
      failures++; $display("FAIL two_dig1 got=%b/%h exp=0010/06", leftseg, a_to_g_left);
    end
    wait_sel(4'b1000);
    wait_sel(4'b0001);
    for (int i = 0; i < 17; i++) begin
      exp_sel = 4'b0001 << ((i / 4) % 4);
      checks++; if (leftseg !== exp_sel || rightseg !== exp_sel) begin
        failures++; $display("FAIL scan_seq[%0d] got=%b/%b exp=%b", i, leftseg, rightseg, exp_sel);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    @(posedge clk);
    #1;
    hold = 1'b1; Datain = 16'h0400;
    repeat (4) tick();
    checks++; if (code !== 4'd10) begin failures++; $display("FAIL hold_live_code got=%0d exp=10", code); end
    Datain = 16'h0000;
    repeat (4) tick();
    checks++; if (code !== 4'd10 || valid !== 1'b1 || ET !== 1'b1) begin
      failures++; $display("FAIL hold_kept got=%0d/%b/%b exp=10/1/1", code, valid, ET);
    end
    wait_sel(4'b0001);
    checks++; if (leftseg !== 4'b0001 || a_to_g_right !== 8'h76 || a_to_g_left !== 8'h3F) begin
      failures++; $display("FAIL hold_dig0 got=%b/%h/%h exp=0001/76/3f", leftseg, a_to_g_right, a_to_g_left);
    end
    @(posedge clk);
    #1;
    hold = 1'b0;
    tick();
    checks++; if (code !== 4'd0 || valid !== 1'b0 || ET !== 1'b1) begin
      failures++; $display("FAIL hold_release got=%0d/%b/%b exp=0/0/1", code, valid, ET);
    end
    tick();
    wait_sel(4'b0001);
    checks++; if (leftseg !== 4'b0001 || a_to_g_left !== 8'h40 || a_to_g_right !== 8'h00) begin
      failures++; $display("FAIL dash_dig0 got=%b/%h/%h exp=0001/40/00", leftseg, a_to_g_left, a_to_g_right);
    end
    wait_sel(4'b0010);
    checks++; if (leftseg !== 4'b0010 || a_to_g_left !== 8'h40) begin
      failures++; $display("FAIL dash_dig1 got=%b/%h exp=0010/40", leftseg, a_to_g_left);
    end
  endtask

  task automatic test_disable();
    @(posedge clk);
    #1;
    n_EN = 1'b1; Datain = 16'hFFFF;
    tick(); tick();
    checks++; if (ET !== 1'b1) begin failures++; $display("FAIL dis_early_et got=%b exp=1", ET); end
    tick();
    checks++; if (code !== 4'd0 || valid !== 1'b0 || ET !== 1'b0) begin
      failures++; $display("FAIL dis_state got=%0d/%b/%b exp=0/0/0", code, valid, ET);
    end
    tick();
    wait_sel(4'b0010);
    checks++; if (leftseg !== 4'b0010 || a_to_g_right !== 8'h79 || a_to_g_left !== 8'h40) begin
      failures++; $display("FAIL dis_dig1 got=%b/%h/%h exp=0010/79/40", leftseg, a_to_g_right, a_to_g_left);
    end
    @(posedge clk);
    #1;
    n_EN = 1'b0; Datain = 16'h0000; hold = 1'b1;
    repeat (4) tick();
    checks++; if (code !== 4'd0 || valid !== 1'b0 || ET !== 1'b1) begin
      failures++; $display("FAIL reen_cleared got=%0d/%b/%b exp=0/0/1", code, valid, ET);
    end
    wait_sel(4'b0001);
    checks++; if (leftseg !== 4'b0001 || a_to_g_right !== 8'h76 || a_to_g_left !== 8'h40) begin
      failures++; $display("FAIL reen_dig0 got=%b/%h/%h exp=0001/76/40", leftseg, a_to_g_right, a_to_g_left);
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk);
    #1;
    hold = 1'b0; Datain = 16'h8001;
    repeat (4) tick();
    checks++; if (code !== 4'd15) begin failures++; $display("FAIL mid_pre_code got=%0d exp=15", code); end
    wait_sel(4'b0100);
    checks++; if (leftseg !== 4'b0100) begin failures++; $display("FAIL mid_pre_sel got=%b exp=0100", leftseg); end
    rst = 1'b1;
    tick();
    checks++; if (leftseg !== 4'b0001 || code !== 4'd0 || valid !== 1'b0 || ET !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%b/%0d/%b/%b exp=0001/0/0/0", leftseg, code, valid, ET);
    end
    checks++; if (a_to_g_left !== 8'h00) begin failures++; $display("FAIL mid_seg got=%h exp=00", a_to_g_left); end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (leftseg !== 4'b0001) begin failures++; $display("FAIL mid_cnt_hold got=%b exp=0001", leftseg); end
    tick();
    checks++; if (leftseg !== 4'b0010) begin failures++; $display("FAIL mid_cnt_adv got=%b exp=0010", leftseg); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_two_digits();
    test_hold();
    test_disable();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
